unidade_controle_drone: RTL and testbench



---
 rtl/unidade_controle_drone.sv | 133 +++++++++++++
 tb/tb_unidade_controle_drone.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_drone.sv
// Drone game control FSM: sequences datapath timer/positions/map read and latches one button press per move.
// Moore machine with registered strobes; no input-to-output combinational path, no backpressure.
module unidade_controle_drone (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic [1:0] botoes,
   input  logic       colisao,
   input  logic       fim_espera,
   input  logic       fim_mapa,
   output logic [1:0] controle,
   output logic       desloca,
   output logic       zeraPosicoes,
   output logic       contaT,
   output logic       zeraT,
   output logic       pronto,
   output logic       ganhou,
   output logic       perdeu,
   output logic [3:0] db_estado
);

   typedef enum logic [2:0] {
      INICIAL = 3'd0,
      PREPARA = 3'd1,
      ESPERA  = 3'd2,
      MOVE    = 3'd3,
      CHECA   = 3'd4,
      AVALIA  = 3'd5,
      PERDEU  = 3'd6,
      GANHOU  = 3'd7
   } estado_t;

   estado_t    estado_q, estado_d;
   logic [1:0] botoes_ant_q;
   logic [1:0] cmd_q, cmd_d;
   logic [1:0] borda;
   logic       borda_valida;

   logic       desloca_q, zera_pos_q, conta_t_q, zera_t_q;
   logic       pronto_q, ganhou_q, perdeu_q;
   logic [3:0] db_estado_q;

   // Exactly one button rising this cycle; a simultaneous double press is rejected.
   assign borda        = botoes & ~botoes_ant_q;
   assign borda_valida = (borda == 2'b01) || (borda == 2'b10);

   always_comb begin
      estado_d = estado_q;
      case (estado_q)
         INICIAL: if (iniciar) estado_d = PREPARA;
         PREPARA: estado_d = ESPERA;
         ESPERA:  if (fim_espera) estado_d = MOVE;
         MOVE:    estado_d = CHECA;
         CHECA:   estado_d = AVALIA;
         AVALIA: begin
            if (colisao)       estado_d = PERDEU;
            else if (fim_mapa) estado_d = GANHOU;
            else               estado_d = ESPERA;
         end
         PERDEU:  if (iniciar) estado_d = PREPARA;
         GANHOU:  if (iniciar) estado_d = PREPARA;
         default: estado_d = INICIAL;
      endcase
   end

   // First valid press per move wins; cleared after the datapath has consumed it.
   always_comb begin
      cmd_d = cmd_q;
      case (estado_q)
         PREPARA, CHECA: cmd_d = 2'b00;
         ESPERA: if ((cmd_q == 2'b00) && borda_valida) cmd_d = borda;
         default: cmd_d = cmd_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         estado_q     <= INICIAL;
         cmd_q        <= 2'b00;
         botoes_ant_q <= 2'b00;
         desloca_q    <= 1'b0;
         zera_pos_q   <= 1'b0;
         conta_t_q    <= 1'b0;
         zera_t_q     <= 1'b0;
         pronto_q     <= 1'b0;
         ganhou_q     <= 1'b0;
         perdeu_q     <= 1'b0;
         db_estado_q  <= 4'd0;
      end else begin
         estado_q     <= estado_d;
         cmd_q        <= cmd_d;
         botoes_ant_q <= botoes;
         db_estado_q  <= {1'b0, estado_d};
         // Strobes are decoded from the next state so they align with the state register.
         desloca_q    <= 1'b0;
         zera_pos_q   <= 1'b0;
         conta_t_q    <= 1'b0;
         zera_t_q     <= 1'b0;
         pronto_q     <= 1'b0;
         ganhou_q     <= 1'b0;
         perdeu_q     <= 1'b0;
         case (estado_d)
            PREPARA: begin
               zera_pos_q <= 1'b1;
               zera_t_q   <= 1'b1;
            end
            ESPERA:  conta_t_q <= 1'b1;
            MOVE:    desloca_q <= 1'b1;
            AVALIA:  zera_t_q  <= 1'b1;
            PERDEU: begin
               pronto_q <= 1'b1;
               perdeu_q <= 1'b1;
            end
            GANHOU: begin
               pronto_q <= 1'b1;
               ganhou_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign controle     = cmd_q;
   assign desloca      = desloca_q;
   assign zeraPosicoes = zera_pos_q;
   assign contaT       = conta_t_q;
   assign zeraT        = zera_t_q;
   assign pronto       = pronto_q;
   assign ganhou       = ganhou_q;
   assign perdeu       = perdeu_q;
   assign db_estado    = db_estado_q;

endmodule

// File: tb/tb_unidade_controle_drone.sv
// Self-checking bench: expected move commands queued per move, compared when desloca fires.
module tb_unidade_controle_drone;

   logic       clock = 1'b0;
   logic       reset, iniciar, colisao, fim_espera, fim_mapa;
   logic [1:0] botoes;
   logic [1:0] controle;
   logic       desloca, zeraPosicoes, contaT, zeraT, pronto, ganhou, perdeu;
   logic [3:0] db_estado;

   int n_checks = 0;
   int n_fail   = 0;
   logic [1:0] exp_q[$];

   unidade_controle_drone dut (
      .clock(clock), .reset(reset), .iniciar(iniciar), .botoes(botoes),
      .colisao(colisao), .fim_espera(fim_espera), .fim_mapa(fim_mapa),
      .controle(controle), .desloca(desloca), .zeraPosicoes(zeraPosicoes),
      .contaT(contaT), .zeraT(zeraT), .pronto(pronto), .ganhou(ganhou),
      .perdeu(perdeu), .db_estado(db_estado)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // {controle, desloca, zeraPosicoes, contaT, zeraT, pronto, ganhou, perdeu}
   function automatic logic [8:0] outs();
      return {controle, desloca, zeraPosicoes, contaT, zeraT, pronto, ganhou, perdeu};
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Scoreboard side: every desloca cycle consumes one expected command.
   always @(negedge clock) begin
      if (desloca === 1'b1) begin
         if (exp_q.size() == 0) chk("unexpected_desloca", 1, 0);
         else chk("controle_at_desloca", int'(controle), int'(exp_q.pop_front()));
      end
   end

   task automatic start_game();
      iniciar = 1'b1; step(); iniciar = 1'b0;
      chk("prepara_st", db_estado, 1);
      chk("prepara_outs", outs(), 9'h028);
      step();
      chk("espera_st", db_estado, 2);
      chk("espera_outs", outs(), 9'h010);
   endtask

   task automatic press(input logic [1:0] v);
      botoes = v; step(); botoes = 2'b00; step();
      chk("press_stay_espera", db_estado, 2);
   endtask

   task automatic do_move(input logic [1:0] exp_cmd, input logic col, input logic fm,
                          input int exp_next);
      exp_q.push_back(exp_cmd);
      fim_espera = 1'b1; step(); fim_espera = 1'b0;
      chk("move_st", db_estado, 3);
      chk("move_outs", outs(), {exp_cmd, 7'h40});
      step();
      chk("checa_st", db_estado, 4);
      chk("checa_outs", outs(), {exp_cmd, 7'h00});
      colisao = col; fim_mapa = fm; step();
      chk("avalia_st", db_estado, 5);
      if (!col && !fm) chk("avalia_outs", outs(), 9'h008);
      step(); colisao = 1'b0; fim_mapa = 1'b0;
      chk("after_avalia_st", db_estado, exp_next);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; iniciar = 1'b0; botoes = 2'b00;
      colisao = 1'b0; fim_espera = 1'b0; fim_mapa = 1'b0;
      step(); step();
      reset = 1'b1;
      chk("reset_st", db_estado, 0);
      chk("reset_outs", outs(), 9'h000);
      step();
      chk("idle_st", db_estado, 0);

      // Start and a single up move
      start_game();
      press(2'b01);
      chk("cmd_latched_up", controle, 2'b01);
      do_move(2'b01, 1'b0, 1'b0, 2);
      chk("cmd_cleared", controle, 2'b00);
      chk("espera_again_outs", outs(), 9'h010);

      // First valid press wins, double press ignored
      press(2'b10);
      press(2'b01);
      do_move(2'b10, 1'b0, 1'b0, 2);
      press(2'b11);
      do_move(2'b00, 1'b0, 1'b0, 2);

      // Held button across two moves
      botoes = 2'b01; step();
      do_move(2'b01, 1'b0, 1'b0, 2);
      step();
      do_move(2'b00, 1'b0, 1'b0, 2);
      botoes = 2'b00; step();

      // Rise during MOVE is discarded and stays held into ESPERA
      exp_q.push_back(2'b00);
      fim_espera = 1'b1; step(); fim_espera = 1'b0;
      botoes = 2'b10;
      step(); step(); step();
      chk("late_press_st", db_estado, 2);
      chk("late_press_cmd", controle, 2'b00);
      botoes = 2'b00;
      do_move(2'b00, 1'b0, 1'b0, 2);

      // Collision beats map end
      do_move(2'b00, 1'b1, 1'b1, 6);
      chk("perdeu_outs", outs(), 9'h005);
      step();
      chk("perdeu_hold_st", db_estado, 6);

      // Win after 16 moves
      start_game();
      for (int i = 0; i < 16; i++)
         do_move(2'b00, 1'b0, (i == 15), (i == 15) ? 7 : 2);
      chk("ganhou_outs", outs(), 9'h006);
      iniciar = 1'b1; step(); iniciar = 1'b0;
      chk("restart_st", db_estado, 1);
      chk("restart_outs", outs(), 9'h028);
      step();

      // Reset mid-game from MOVE
      press(2'b10);
      exp_q.push_back(2'b10);
      fim_espera = 1'b1; step(); fim_espera = 1'b0;
      chk("pre_reset_move_st", db_estado, 3);
      reset = 1'b0; step(); step(); reset = 1'b1;
      chk("midreset_st", db_estado, 0);
      chk("midreset_outs", outs(), 9'h000);
      step();
      chk("post_reset_outs", outs(), 9'h000);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
